// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the calculator multiply path: default operand width,
// FSM state encoding and the step-counter width helper.
package seq_multiplier_pkg;

  localparam int unsigned CALC_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must be able to represent 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_mult_step.sv
// One shift-add step of the multiplier: conditionally add B into the upper
// half of the partial product, then shift the whole register right by one.
module mult_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2*WIDTH:0] p,
  input  logic [WIDTH-1:0] b,
  output logic [2*WIDTH:0] p_next
);

  logic [WIDTH:0] addend_term;
  logic [WIDTH:0] sum;

  // p[2W] is always zero between steps, so the W+1-bit sum over p[2W:W]
  // equals the sum over p[2W-1:W] with room for the carry.
  always_comb begin
    addend_term = p[0] ? {1'b0, b} : '0;
    sum         = p[2*WIDTH:WIDTH] + addend_term;
    p_next      = {1'b0, sum, p[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential sign-magnitude shift-add multiplier: Res = A*B + Addend,
// one multiplier bit per clock. Signs ride alongside the magnitudes.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   Addend,
  input  logic               Asign,
  input  logic               Bsign,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Res,
  output logic               negative,
  output logic               overflow
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [2*WIDTH:0]     p_q, p_d, p_step;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 sign_q, sign_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 negative_q, negative_d;
  logic                 overflow_q, overflow_d;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_q),
    .b      (b_q),
    .p_next (p_step)
  );

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      p_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_q      <= '0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_q      <= res_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state and result logic. The final step registers its result directly
  // so that back-to-back operations complete every WIDTH+1 cycles.
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    b_d        = b_q;
    sign_d     = sign_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    res_d      = res_q;
    negative_d = negative_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          p_d     = {1'b0, Addend, A};
          b_d     = B;
          sign_d  = Asign ^ Bsign;
          count_d = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        p_d     = p_step;
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          state_d    = ST_DONE;
          res_d      = p_step[2*WIDTH-1:0];
          overflow_d = |p_step[2*WIDTH-1:WIDTH];
          negative_d = sign_q & (|p_step[2*WIDTH-1:0]);
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Res      = res_q;
  assign negative = negative_q;
  assign overflow = overflow_q;

endmodule
